// File: rtl/seq_mag_comp_if.sv
// Start/busy/done bus of the sequential magnitude comparator.
// master drives the request fields, slave (the comparator) drives the status fields.
interface seq_mag_comp_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [1:0]       result;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/seq_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, with optional
// early exit on the first unequal slice. Result code: 10 a>b, 01 a<b, 00 equal.
module seq_mag_comp #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    seq_mag_comp_if.slave       bus,
    output logic                state_dbg
);
    // Handshake: start is sampled only while idle (busy=0); done pulses for one
    // cycle when result updates, and result holds until the next completion.

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]    LAST     = IW'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx_q;
    logic             found_q, gt_q;
    logic             done_q, done_d;
    logic [1:0]       result_q, result_d;
    logic             launch;

    logic [DIGIT-1:0] sa, sb;
    logic             slice_ne, slice_gt, any_diff, verdict_gt, finish;

    // Operands shift left each cycle, so the slice under test is always the top one.
    assign sa         = a_q[WIDTH-1 -: DIGIT];
    assign sb         = b_q[WIDTH-1 -: DIGIT];
    assign slice_ne   = (sa != sb);
    assign slice_gt   = (sa > sb);
    assign any_diff   = found_q | slice_ne;
    assign verdict_gt = found_q ? gt_q : slice_gt;
    assign finish     = (idx_q == LAST) || ((EARLY_EXIT != 0) && slice_ne);

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        result_d = result_q;
        launch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    launch  = 1'b1;
                end
            end
            RUN: begin
                if (finish) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    result_d = any_diff ? (verdict_gt ? 2'b10 : 2'b01) : 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            result_q <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            found_q  <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            if (launch) begin
                // Flipping the MSB maps two's complement onto offset binary.
                a_q     <= bus.a ^ (bus.signed_mode ? MSB_MASK : '0);
                b_q     <= bus.b ^ (bus.signed_mode ? MSB_MASK : '0);
                idx_q   <= '0;
                found_q <= 1'b0;
                gt_q    <= 1'b0;
            end else if (state_q == RUN) begin
                a_q     <= a_q << DIGIT;
                b_q     <= b_q << DIGIT;
                idx_q   <= idx_q + 1'b1;
                found_q <= any_diff;
                gt_q    <= verdict_gt;
            end
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed-vector bench for seq_mag_comp: an early-exit instance and a
// fixed-latency instance share clock and reset.
module tb_seq_mag_comp;
    logic clk;
    logic rst;
    logic e_state, f_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] exp_q[$];

    seq_mag_comp_if #(.WIDTH(16)) e_if ();
    seq_mag_comp_if #(.WIDTH(16)) f_if ();

    seq_mag_comp #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .rst(rst), .bus(e_if), .state_dbg(e_state)
    );
    seq_mag_comp #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) dut_f (
        .clk(clk), .rst(rst), .bus(f_if), .state_dbg(f_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive start for one edge from a negedge; returns at the negedge after E0.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic sm);
        e_if.start = 1'b1;
        e_if.a = av;
        e_if.b = bv;
        e_if.signed_mode = sm;
        @(posedge clk);
        @(negedge clk);
        e_if.start = 1'b0;
    endtask

    // Returns k such that done is seen at the negedge after E0+k; -1 on timeout.
    task automatic wait_done(input int j0, output int k);
        k = -1;
        for (int j = j0 + 1; j <= 8; j++) begin
            @(negedge clk);
            if (e_if.done) begin
                k = j;
                break;
            end
        end
        if (k < 0) check("done_timeout", 1, 0);
    endtask

    task automatic score(input string tag);
        logic [1:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, e_if.result, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic sm, input logic [1:0] exp_r, input int exp_k);
        int k;
        exp_q.push_back(exp_r);
        launch(av, bv, sm);
        check({tag, "_busy"}, e_if.busy, 1);
        wait_done(0, k);
        check({tag, "_k"}, k, exp_k);
        score(tag);
        check({tag, "_busy_at_done"}, e_if.busy, 0);
        @(negedge clk);
        check({tag, "_done_drop"}, e_if.done, 0);
        check({tag, "_hold"}, e_if.result, exp_r);
    endtask

    task automatic fixed_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic [1:0] exp_r);
        int busy_cycles = 0;
        f_if.start = 1'b1;
        f_if.a = av;
        f_if.b = bv;
        f_if.signed_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        f_if.start = 1'b0;
        while (f_if.busy && busy_cycles < 10) begin
            busy_cycles++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, busy_cycles, 4);
        check({tag, "_done"}, f_if.done, 1);
        check({tag, "_result"}, f_if.result, exp_r);
    endtask

    initial begin
        int k;
        int pulses;
        rst = 1'b1;
        e_if.start = 1'b0; e_if.a = '0; e_if.b = '0; e_if.signed_mode = 1'b0;
        f_if.start = 1'b0; f_if.a = '0; f_if.b = '0; f_if.signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", e_if.busy, 0);
        check("rst_done", e_if.done, 0);
        check("rst_result", e_if.result, 2'b00);
        check("rst_state", e_state, 0);

        do_op("gt_early",   16'h7FFF, 16'h0000, 1'b0, 2'b10, 1);
        do_op("lt_lsb",     16'h1234, 16'h1235, 1'b0, 2'b01, 4);
        do_op("eq_u",       16'hABCD, 16'hABCD, 1'b0, 2'b00, 4);
        do_op("s_min_vs_1", 16'h8000, 16'h0001, 1'b1, 2'b01, 1);
        do_op("u_8000_vs_1",16'h8000, 16'h0001, 1'b0, 2'b10, 1);
        do_op("s_eq",       16'hFFFF, 16'hFFFF, 1'b1, 2'b00, 4);
        do_op("s_m1_vs_0",  16'hFFFF, 16'h0000, 1'b1, 2'b01, 1);

        // A second start during RUN must be ignored.
        exp_q.push_back(2'b10);
        launch(16'h00F0, 16'h000F, 1'b0);
        e_if.start = 1'b1; e_if.a = 16'h0000; e_if.b = 16'hFFFF;
        @(negedge clk);
        e_if.start = 1'b0;
        check("ign_no_early_done", e_if.done, 0);
        wait_done(1, k);
        check("ign_k", k, 3);
        score("ign");

        // Start in the done cycle is accepted with no bubble.
        exp_q.push_back(2'b01);
        launch(16'h0000, 16'h1000, 1'b0);
        check("b2b_busy", e_if.busy, 1);
        check("b2b_prev_result_held", e_if.result, 2'b10);
        wait_done(0, k);
        check("b2b_k", k, 1);
        score("b2b");
        @(negedge clk);

        // Reset mid-RUN aborts with no done pulse.
        launch(16'h0001, 16'h0002, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", e_if.busy, 0);
        check("abort_done", e_if.done, 0);
        check("abort_result", e_if.result, 2'b00);
        pulses = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (e_if.done) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        do_op("after_abort", 16'h0001, 16'h0002, 1'b0, 2'b01, 4);

        // Reset coincident with start wins.
        e_if.start = 1'b1; e_if.a = 16'h0005; e_if.b = 16'h0003;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e_if.start = 1'b0;
        check("rst_start_busy", e_if.busy, 0);
        check("rst_start_result", e_if.result, 2'b00);

        fixed_op("fix_7fff", 16'h7FFF, 16'h0000, 2'b10);
        fixed_op("fix_noovr", 16'h1000, 16'h0FFF, 2'b10);
        fixed_op("fix_lt", 16'h0FFF, 16'h1000, 2'b01);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
- Parametrised, multi-cycle magnitude comparator; successor to the team's 4-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, with optional early exit on the first differing slice.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Sits behind a start/busy/done handshake. Keeps the established 2-bit result code: 10 = a>b, 01 = a<b, 00 = equal.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT and at least 2.
- DIGIT, 4, bits compared per clock cycle; 1 <= DIGIT <= WIDTH.
- EARLY_EXIT, 1, 1 = finish on first unequal slice; 0 = always run all WIDTH/DIGIT slices (fixed latency).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a comparison; sampled only when busy=0.
- signed_mode  input  1  1 = operands are two's complement; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  2  10 a>b, 01 a<b, 00 a==b; held until next completion.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=00, internal operand registers and slice counter cleared.
- The FSM has two states, IDLE and RUN. N = WIDTH/DIGIT slices.
- IDLE -> RUN: start=1 at a rising edge.
  - Latch a, b and signed_mode.
  - In signed mode, invert the MSB of both latched operands (offset-binary conversion), so the rest of the datapath is purely unsigned.
  - Set slice index i=0 and busy=1.
- RUN, each cycle: compare slice i, bits [WIDTH-1-i*DIGIT -: DIGIT], of both latched operands, with slice 0 as the MSB slice.
  - Track a first-difference flag and its verdict. Only the first unequal slice determines the verdict; later slices never override it.
- Completion edge:
  - EARLY_EXIT=1: the edge at which the first unequal slice is evaluated.
  - Otherwise: the edge at which slice N-1 is evaluated.
  - At that edge: result <= verdict, or 00 if no difference was found; done <= 1; busy <= 0; state <= IDLE.
- Latency: if start is sampled at edge E0, done is high during the cycle after edge E0+k.
  - k = 1-based index of the first differing slice when EARLY_EXIT=1 and a!=b.
  - k = N otherwise.
  - Minimum latency is 1 cycle; maximum is N.
- done deasserts at the next edge. result holds its value until the next completion edge. result does not change during RUN.
- start while busy=1 is ignored; there is no queueing, and the latched operands do not change.
- start high in the cycle where done=1 is accepted, because the FSM is already IDLE. Back-to-back operations therefore run with no bubble.
- A held start launches a new operation at every IDLE edge.
- rst=1 at any edge, including mid-RUN or coincident with start, overrides everything and returns to the reset values. No done pulse is produced for the aborted operation.
- Input changes on a, b or signed_mode during RUN have no effect.
- DIGIT=WIDTH gives a 1-cycle comparator. DIGIT=1 gives a bit-serial comparator.
- Signed-mode equality: identical bit patterns give 00 in both modes.

Test Plan:
- WIDTH=16, DIGIT=4, EARLY_EXIT=1, unsigned, a=0x7FFF, b=0x0000, start one cycle -> busy=1 for 1 cycle; done pulses 1 cycle after the start edge; result=10.
- a=0x1234, b=0x1235, unsigned -> k=4; done 4 cycles after start; result=01. Then a=b=0xABCD -> k=4, result=00.
- Signed mode, a=0x8000 (-32768), b=0x0001 -> result=01, k=1. Same operands with signed_mode=0 -> result=10, k=1.
- Launch a=0x00F0, b=0x000F; pulse start again at cycle 1 with a=0, b=0xFFFF -> second start ignored; result=10 at k=3. Then issue start in the done cycle -> new operation accepted with no idle cycle.
- Start a=0x0001, b=0x0002; assert rst at cycle 2 of RUN -> busy=0, done never pulses, result=00. The next start completes normally.
- EARLY_EXIT=0 build, a=0x7FFF, b=0x0000 -> busy for exactly 4 cycles; result=10; the verdict from slice 0 is not overridden by slices 1-3 (0xFFF vs 0x000).
